// File: rtl/serial_frame_pkg.sv
// Shared constants for the RS232 lidar frame receiver: header/trailer bytes, FSM and error encodings.
// No logic of its own; zero latency.
// No flow control here; the backpressure rules live in serial_frame_recv.
package serial_frame_pkg;

    localparam logic [7:0] SD1 = 8'h7B;
    localparam logic [7:0] SD2 = 8'h28;
    localparam logic [7:0] SD3 = 8'h31;
    localparam logic [7:0] SD4 = 8'h30;
    localparam logic [7:0] SD5 = 8'h32;
    localparam logic [7:0] SD6 = 8'h34;
    localparam logic [7:0] SD7 = 8'h29;
    localparam logic [7:0] SD8 = 8'h7D;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        PAYLOAD = 2'd1,
        TRAIL   = 2'd2
    } frame_state_e;

    typedef enum logic [1:0] {
        URX_IDLE  = 2'd0,
        URX_START = 2'd1,
        URX_DATA  = 2'd2,
        URX_STOP  = 2'd3
    } uart_state_e;

    localparam logic [1:0] ERR_TRAIL    = 2'd0;
    localparam logic [1:0] ERR_FRAMING  = 2'd1;
    localparam logic [1:0] ERR_OVERFLOW = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

    function automatic logic [7:0] hdr_byte(input logic [2:0] idx);
        case (idx)
            3'd0:    hdr_byte = SD1;
            3'd1:    hdr_byte = SD2;
            3'd2:    hdr_byte = SD3;
            3'd3:    hdr_byte = SD4;
            3'd4:    hdr_byte = SD5;
            default: hdr_byte = SD6;
        endcase
    endfunction

endpackage

// File: rtl/frame_uart_rx.sv
// 8N1 UART deserialiser: 2-FF sync, mid-bit sampling, glitch-filtered start bit.
// byte_vld / frm_err assert combinationally in the mid-stop-bit sample cycle.
// No backpressure: the byte is offered for a single cycle and must be taken then.
module frame_uart_rx
    import serial_frame_pkg::*;
#(
    parameter int BAUD_DIV = 5208
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rs232_rx,
    output logic [7:0] rx_byte,
    output logic       byte_vld,
    output logic       frm_err
);
    localparam int CW   = $clog2(BAUD_DIV);
    localparam int HALF = BAUD_DIV / 2;

    logic          rx_meta_q, rx_sync_q, rx_prev_q;
    uart_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tick;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
            state_q   <= URX_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
        end else begin
            rx_meta_q <= rs232_rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
        end
    end

    // The start bit is checked half a bit in; every later sample is a full bit apart.
    assign tick = (state_q == URX_START) ? (cnt_q == CW'(HALF - 1))
                                         : (cnt_q == CW'(BAUD_DIV - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        unique case (state_q)
            URX_IDLE: begin
                cnt_d = '0;
                if (!rx_sync_q && rx_prev_q) state_d = URX_START;
            end
            URX_START: if (tick) begin
                cnt_d   = '0;
                bit_d   = '0;
                state_d = rx_sync_q ? URX_IDLE : URX_DATA;
            end
            URX_DATA: if (tick) begin
                cnt_d   = '0;
                shift_d = {rx_sync_q, shift_q[7:1]};
                bit_d   = bit_q + 3'd1;
                if (bit_q == 3'd7) state_d = URX_STOP;
            end
            URX_STOP: if (tick) begin
                cnt_d   = '0;
                state_d = URX_IDLE;
            end
            default: state_d = URX_IDLE;
        endcase
    end

    always_comb begin
        rx_byte  = shift_q;
        byte_vld = (state_q == URX_STOP) && tick &&  rx_sync_q;
        frm_err  = (state_q == URX_STOP) && tick && !rx_sync_q;
    end

endmodule

// File: rtl/serial_frame_recv.sv
// Lidar frame receiver: hunts "{(1024", forwards payload, checks ")}"; SERIAL_FRAME_RX_TIMEOUT_EN adds an inter-byte timeout.
// All outputs are registered: 1 cycle from the UART byte to out_wrreq / frame_* pulses.
// out_full on a payload byte aborts the frame (overflow error) instead of stalling.
module serial_frame_recv
    import serial_frame_pkg::*;
#(
    parameter int BAUD_DIV    = 5208,
    parameter int PAYLOAD_LEN = 1024,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rs232_rx,
    input  logic        recv_en,
    input  logic        out_full,
    output logic [7:0]  out_data,
    output logic        out_wrreq,
    output logic        frame_start,
    output logic        frame_done,
    output logic        frame_err,
    output logic [1:0]  err_code,
    output logic [15:0] frame_cnt
);
    localparam int PCW = $clog2(PAYLOAD_LEN) + 1;
    localparam int TCW = $clog2(TIMEOUT_CYC + 1);

    logic [7:0] rx_byte;
    logic       byte_vld, frm_err;

    frame_uart_rx #(.BAUD_DIV(BAUD_DIV)) u_uart_rx (
        .clk      (clk),
        .rst      (rst),
        .rs232_rx (rs232_rx),
        .rx_byte  (rx_byte),
        .byte_vld (byte_vld),
        .frm_err  (frm_err)
    );

    frame_state_e    state_q, state_d;
    logic [2:0]      hidx_q, hidx_d;
    logic            tidx_q, tidx_d;
    logic [PCW-1:0]  pcnt_q, pcnt_d;
    logic [7:0]      out_data_q, out_data_d;
    logic            wrreq_q, wrreq_d;
    logic            start_q, start_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [1:0]      err_code_q, err_code_d;
    logic [15:0]     frame_cnt_q, frame_cnt_d;
    logic            expire;

`ifdef SERIAL_FRAME_RX_TIMEOUT_EN
    logic [TCW-1:0]  to_cnt_q, to_cnt_d;
    logic            waiting;

    always_ff @(posedge clk) begin
        if (rst) to_cnt_q <= '0;
        else     to_cnt_q <= to_cnt_d;
    end

    always_comb begin
        waiting  = (state_q != HUNT) || (hidx_q != 3'd0);
        expire   = recv_en && waiting && (to_cnt_q == TCW'(TIMEOUT_CYC - 1));
        to_cnt_d = (byte_vld || !waiting || expire || !recv_en) ? '0 : to_cnt_q + 1'b1;
    end
`else
    // Parameter kept for a uniform interface; without the timeout it only sizes an unused tie-off.
    logic [TCW-1:0] unused_timeout;
    assign unused_timeout = '0;
    assign expire         = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= HUNT;
            hidx_q      <= '0;
            tidx_q      <= 1'b0;
            pcnt_q      <= '0;
            out_data_q  <= '0;
            wrreq_q     <= 1'b0;
            start_q     <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= '0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            hidx_q      <= hidx_d;
            tidx_q      <= tidx_d;
            pcnt_q      <= pcnt_d;
            out_data_q  <= out_data_d;
            wrreq_q     <= wrreq_d;
            start_q     <= start_d;
            done_q      <= done_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        hidx_d      = hidx_q;
        tidx_d      = tidx_q;
        pcnt_d      = pcnt_q;
        out_data_d  = out_data_q;
        wrreq_d     = 1'b0;
        start_d     = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        err_code_d  = err_code_q;
        frame_cnt_d = frame_cnt_q;
        if (!recv_en) begin
            state_d = HUNT;
            hidx_d  = '0;
        end else if (frm_err) begin
            if (state_q != HUNT) begin
                err_d      = 1'b1;
                err_code_d = ERR_FRAMING;
            end
            state_d = HUNT;
            hidx_d  = '0;
        end else if (byte_vld) begin
            unique case (state_q)
                HUNT: begin
                    if (rx_byte == hdr_byte(hidx_q)) begin
                        if (hidx_q == 3'd5) begin
                            start_d = 1'b1;
                            state_d = PAYLOAD;
                            pcnt_d  = '0;
                            hidx_d  = '0;
                        end else begin
                            hidx_d = hidx_q + 3'd1;
                        end
                    end else begin
                        // A stray '{' may itself open the real header.
                        hidx_d = (rx_byte == SD1) ? 3'd1 : 3'd0;
                    end
                end
                PAYLOAD: begin
                    if (out_full) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_OVERFLOW;
                        state_d    = HUNT;
                        hidx_d     = '0;
                    end else begin
                        out_data_d = rx_byte;
                        wrreq_d    = 1'b1;
                        if (pcnt_q == PCW'(PAYLOAD_LEN - 1)) begin
                            state_d = TRAIL;
                            tidx_d  = 1'b0;
                        end else begin
                            pcnt_d = pcnt_q + 1'b1;
                        end
                    end
                end
                TRAIL: begin
                    if (rx_byte == (tidx_q ? SD8 : SD7)) begin
                        if (tidx_q) begin
                            done_d      = 1'b1;
                            frame_cnt_d = frame_cnt_q + 16'd1;
                            state_d     = HUNT;
                            hidx_d      = '0;
                        end else begin
                            tidx_d = 1'b1;
                        end
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = ERR_TRAIL;
                        state_d    = HUNT;
                        hidx_d     = (rx_byte == SD1) ? 3'd1 : 3'd0;
                    end
                end
                default: begin
                    state_d = HUNT;
                    hidx_d  = '0;
                end
            endcase
        end else if (expire) begin
            if (state_q != HUNT) begin
                err_d      = 1'b1;
                err_code_d = ERR_TIMEOUT;
            end
            state_d = HUNT;
            hidx_d  = '0;
        end
    end

    always_comb begin
        out_data    = out_data_q;
        out_wrreq   = wrreq_q;
        frame_start = start_q;
        frame_done  = done_q;
        frame_err   = err_q;
        err_code    = err_code_q;
        frame_cnt   = frame_cnt_q;
    end

endmodule
